logic_op_stage: RTL and testbench
=================================

LOGIC_OP_STAGE -- requirements
Module: logic_op_stage

Interface
REQ-001 The module SHALL have parameter size, default 4, giving the operand and result width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit, indicating the upstream operation is valid.
REQ-005 The module SHALL have port in_ready, output, 1 bit, indicating the stage accepts an operation this cycle.
REQ-006 The module SHALL have port op, input, 2 bits, selecting the operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-007 The module SHALL have ports a and b, input, size bits each, the operands.
REQ-008 The module SHALL have port out_valid, output, 1 bit, indicating the head result is valid.
REQ-009 The module SHALL have port out_ready, input, 1 bit, indicating the downstream consumer takes the head result.
REQ-010 The module SHALL have port result, output, size bits, the head result.
REQ-011 The module SHALL have port zero, output, 1 bit, high when the head result is all zeros.
REQ-012 The module SHALL have port parity, output, 1 bit, the XOR of all head result bits.
REQ-013 The module SHALL have port op_count, output, 8 bits, counting results delivered downstream.

Function
REQ-014 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both high; an output transfer SHALL occur where out_valid and out_ready are both high.
REQ-015 On input transfer the stage SHALL compute result = op(a, b) bitwise over all size bits, with zero and parity computed from that result, and store all three as one entry.
REQ-016 Storage SHALL be a 2-entry FIFO with states EMPTY (0 entries), ONE (1 entry) and FULL (2 entries); out_valid SHALL be high in ONE and FULL only.
REQ-017 Latency SHALL be one cycle: an entry accepted at edge N SHALL appear on result/zero/parity with out_valid high after edge N when the FIFO was EMPTY.
REQ-018 in_ready SHALL be high in EMPTY and ONE and low in FULL, registered and independent of out_ready in the same cycle.
REQ-019 Transitions SHALL be as follows: EMPTY to ONE on input; ONE to FULL on input without output; ONE to EMPTY on output without input; ONE stays ONE on simultaneous input and output; FULL to ONE on output.
REQ-020 In FULL, in_valid SHALL be ignored; no entry is overwritten or dropped.
REQ-021 Results SHALL leave in acceptance order; the head SHALL remain stable while out_valid is high and out_ready is low.
REQ-022 op_count SHALL increment by 1 on each output transfer and wrap from 255 to 0.
REQ-023 Operand width SHALL be exact: no carry and no sign extension; bit i of result SHALL depend only on bit i of a and b.

Reset
REQ-024 Asserting rst_n low SHALL immediately, without waiting for a clock, force state EMPTY, in_ready 0, out_valid 0, result 0, zero 1, parity 0 and op_count 0.
REQ-025 in_ready SHALL rise on the first rising edge after rst_n deasserts; entries in flight at reset SHALL be discarded.

Verification
REQ-026 Verification SHALL cover this case: after reset, issue op=01, a=4'b1010, b=4'b0101, with out_ready high -> next cycle result=4'b1111, zero=0, parity=0, out_valid=1, op_count becomes 1 on the following edge.
REQ-027 Verification SHALL cover this case: op=00, a=4'b1100, b=4'b0011 -> result=4'b0000, zero=1, parity=0; op=11, a=b=4'b0000 -> result=4'b1111.
REQ-028 Verification SHALL cover this case: hold out_ready low and issue three ops back-to-back -> first two accepted, in_ready=0 after the second, third held by upstream; head result unchanged until out_ready rises, then order is preserved.
REQ-029 Verification SHALL cover this case: in ONE, pulse in_valid and out_ready in the same cycle for 10 cycles -> state stays ONE and op_count advances by 10.
REQ-030 Verification SHALL cover this case: drive rst_n low mid-cycle while FULL -> out_valid, in_ready and op_count go to 0 before the next clock edge, and no stale result appears after release.
REQ-031 Verification SHALL cover this case: 256 output transfers -> op_count returns to 0.

Source files
------------

// File: rtl/logic_op_stage.sv
// ---------------------------------------------------------------------------
// logic_op_stage
//
// Single-cycle bitwise logic unit followed by a 2-entry output FIFO with
// valid/ready handshakes on both sides. Every accepted operation produces one
// entry {parity, zero, result}. Entries leave in acceptance order.
//
// Parameters
//   size       operand and result width in bits
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream offers an operation
//   in_ready   stage accepts an operation this cycle (registered)
//   op         00 AND, 01 OR, 10 XOR, 11 NOR
//   a, b       operands
//   out_valid  head entry is valid
//   out_ready  downstream takes the head entry
//   result     head result
//   zero       head result is all zeros
//   parity     XOR of all head result bits
//   op_count   number of results delivered downstream, wraps at 256
// ---------------------------------------------------------------------------
module logic_op_stage #(
    parameter int size = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [size-1:0] result,
    output logic            zero,
    output logic            parity,
    output logic [7:0]      op_count
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    // Entry layout: {parity, zero, result}. The reset value describes an
    // all-zero result so the flag outputs stay self-consistent in reset.
    localparam logic [size+1:0] reset_entry = {1'b0, 1'b1, {size{1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [size+1:0] head_q, head_d;
    logic [size+1:0] tail_q, tail_d;
    logic [size-1:0] calc;
    logic [size+1:0] new_entry;
    logic            in_ready_q;
    logic [7:0]      op_count_q;
    logic            in_fire;
    logic            out_fire;

    // Pure bitwise operations: bit i of the result only sees bit i of a and b.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a value
        // on every path, otherwise synthesis infers a latch.
        calc = '0;
        case (op)
            2'b00:   calc = a & b;
            2'b01:   calc = a | b;
            2'b10:   calc = a ^ b;
            default: calc = ~(a | b);
        endcase
        new_entry = {^calc, ~|calc, calc};
    end

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    head_d  = new_entry;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    // Head leaves and the new entry takes its place.
                    head_d = new_entry;
                end else if (in_fire) begin
                    state_d = FULL;
                    tail_d  = new_entry;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so no input can be accepted.
                if (out_fire) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two storage entries are reset along with the control
            // state so the outputs show a defined result during reset and no
            // stale entry can reappear after release.
            state_q    <= EMPTY;
            head_q     <= reset_entry;
            tail_q     <= reset_entry;
            in_ready_q <= 1'b0;
            op_count_q <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its sources.
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            // Registered ready: derived from the next state, never from the
            // current out_ready.
            in_ready_q <= (state_d != FULL);
            if (out_fire) begin
                op_count_q <= op_count_q + 8'd1;
            end
        end
    end

    assign result   = head_q[size-1:0];
    assign zero     = head_q[size];
    assign parity   = head_q[size+1];
    assign op_count = op_count_q;

endmodule

// File: tb/tb_logic_op_stage.sv
module tb_logic_op_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result;
    logic       zero;
    logic       parity;
    logic [7:0] op_count;

    int n_cmp;
    int n_bad;
    int xfers;            // output transfers seen since last reset
    logic [5:0] sb[$];    // expected {parity, zero, result}

    logic_op_stage #(.size(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .parity   (parity),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, computed bit by bit.
    function automatic logic [5:0] model(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
        logic [3:0] r;
        logic       p;
        r = 4'b0000;
        p = 1'b0;
        for (int i = 0; i < 4; i++) begin
            case (o)
                2'b00:   r[i] = x[i] & y[i];
                2'b01:   r[i] = x[i] | y[i];
                2'b10:   r[i] = x[i] ^ y[i];
                default: r[i] = !(x[i] | y[i]);
            endcase
            p = p ^ r[i];
        end
        return {p, (r == 4'b0000), r};
    endfunction

    // One clock cycle: drive at the falling edge, observe the handshake the
    // rising edge will see, then score the transfers just after that edge.
    task automatic step(input logic iv, input logic [1:0] o, input logic [3:0] aa,
                        input logic [3:0] bb, input logic ordy, output logic acc);
        logic       ifire;
        logic       ofire;
        logic [5:0] seen;
        logic [5:0] exp;
        @(negedge clk);
        in_valid  = iv;
        op        = o;
        a         = aa;
        b         = bb;
        out_ready = ordy;
        #1;
        ifire = iv && in_ready;
        ofire = out_valid && ordy;
        seen  = {parity, zero, result};
        @(posedge clk);
        #1;
        acc = ifire;
        if (ofire) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: output transfer with nothing expected, got %b", seen);
            end else begin
                exp = sb.pop_front();
                if (seen !== exp) begin
                    n_bad++;
                    $display("FAIL sb_entry: got {p,z,r}=%b want %b", seen, exp);
                end
            end
            xfers++;
        end
        if (ifire) sb.push_back(model(o, aa, bb));
        n_cmp++;
        if (out_valid !== (sb.size() != 0)) begin
            n_bad++;
            $display("FAIL out_valid: got %b want %b", out_valid, (sb.size() != 0));
        end
        n_cmp++;
        if (in_ready !== (sb.size() < 2)) begin
            n_bad++;
            $display("FAIL in_ready: got %b want %b", in_ready, (sb.size() < 2));
        end
        n_cmp++;
        if (op_count !== xfers[7:0]) begin
            n_bad++;
            $display("FAIL op_count: got %0d want %0d", op_count, xfers[7:0]);
        end
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 8 && sb.size() != 0; i++) step(1'b0, 2'b00, 4'h0, 4'h0, 1'b1, acc);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d entries left", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = 4'h0; b = 4'h0;
        #23;
        n_cmp++;
        if ({in_ready, out_valid, result, zero, parity, op_count} !== {1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_values: rdy=%b vld=%b res=%b z=%b p=%b cnt=%0d want 0 0 0000 1 0 0",
                     in_ready, out_valid, result, zero, parity, op_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_before_edge: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_edge: got %b want 1", in_ready);
        end
        sb.delete();
        xfers = 0;
    endtask

    task automatic test_basic();
        logic acc;
        step(1'b1, 2'b01, 4'b1010, 4'b0101, 1'b1, acc);
        n_cmp++;
        if ({out_valid, result, zero, parity, op_count} !== {1'b1, 4'b1111, 1'b0, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL or_case: vld=%b res=%b z=%b p=%b cnt=%0d want 1 1111 0 0 0",
                     out_valid, result, zero, parity, op_count);
        end
        step(1'b1, 2'b00, 4'b1100, 4'b0011, 1'b1, acc);
        n_cmp++;
        if (op_count !== 8'd1) begin
            n_bad++;
            $display("FAIL count_after_first: got %0d want 1", op_count);
        end
        n_cmp++;
        if ({result, zero, parity} !== {4'b0000, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL and_case: res=%b z=%b p=%b want 0000 1 0", result, zero, parity);
        end
        step(1'b1, 2'b11, 4'b0000, 4'b0000, 1'b1, acc);
        n_cmp++;
        if ({result, zero, parity} !== {4'b1111, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL nor_case: res=%b z=%b p=%b want 1111 0 0", result, zero, parity);
        end
        step(1'b1, 2'b10, 4'b0110, 4'b0011, 1'b1, acc);
        drain();
    endtask

    task automatic test_back_to_back();
        logic acc;
        logic got_third;
        step(1'b1, 2'b10, 4'b1001, 4'b0011, 1'b0, acc);
        step(1'b1, 2'b01, 4'b0001, 4'b0100, 1'b0, acc);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_ready: got %b want 0", in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'b00, 4'b1111, 4'b0110, 1'b0, acc);
            n_cmp++;
            if (acc || result !== 4'b1010) begin
                n_bad++;
                $display("FAIL head_hold: acc=%b res=%b want 0 1010", acc, result);
            end
        end
        got_third = 1'b0;
        for (int i = 0; i < 6 && !got_third; i++) begin
            step(1'b1, 2'b00, 4'b1111, 4'b0110, 1'b1, acc);
            got_third = acc;
        end
        n_cmp++;
        if (!got_third) begin
            n_bad++;
            $display("FAIL third_accept: got 0 want 1");
        end
        drain();
    endtask

    task automatic test_simultaneous();
        logic acc;
        int   start;
        step(1'b1, 2'b01, 4'b0010, 4'b0001, 1'b0, acc);
        start = xfers;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 2'($urandom_range(3)), 4'($urandom), 4'($urandom), 1'b1, acc);
        end
        n_cmp++;
        if (op_count !== 8'(start + 10) || sb.size() != 1) begin
            n_bad++;
            $display("FAIL simultaneous: cnt=%0d want %0d, depth=%0d want 1", op_count, 8'(start + 10), sb.size());
        end
        drain();
    endtask

    task automatic test_reset_full();
        logic acc;
        step(1'b1, 2'b10, 4'b1100, 4'b1010, 1'b0, acc);
        step(1'b1, 2'b00, 4'b1110, 4'b0111, 1'b0, acc);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, op_count, result, zero} !== {1'b0, 1'b0, 8'd0, 4'h0, 1'b1}) begin
            n_bad++;
            $display("FAIL async_reset: vld=%b rdy=%b cnt=%0d res=%b z=%b want 0 0 0 0000 1",
                     out_valid, in_ready, op_count, result, zero);
        end
        sb.delete();
        xfers = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 4'h0, 4'h0, 1'b1, acc);
    endtask

    task automatic test_wrap();
        logic acc;
        for (int i = 0; i < 600 && xfers < 256; i++) begin
            step(1'b1, 2'($urandom_range(3)), 4'($urandom), 4'($urandom), (xfers < 255) || (sb.size() != 0), acc);
        end
        n_cmp++;
        if (xfers != 256 || op_count !== 8'd0) begin
            n_bad++;
            $display("FAIL wrap: xfers=%0d cnt=%0d want 256 0", xfers, op_count);
        end
        drain();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        xfers = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_simultaneous();
        test_reset_full();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
